// File: rtl/nfc_ecc_wb.sv
// rtl/nfc_ecc_wb.sv - ECC write-back engine: parity words to page buffer, bit corrections in page buffer
module nfc_ecc_wb #(
   parameter int DAT_WID   = 16,
   parameter int ECC_AWID  = 12,
   parameter int BUF_AWID  = 12,
   parameter int PAR_WORDS = 7,
   parameter int MAX_ERR   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                nfc_dat_dir,
   input  logic                nfc_ecc_opt,
   input  logic                ecc_enc_rdy,
   input  logic                ecc_dec_rdy,
   input  logic [3:0]          err_cnt,
   input  logic [BUF_AWID-1:0] sec_base,
   input  logic [BUF_AWID-1:0] par_base,
   output logic                mem_if_rd,
   input  logic [DAT_WID-1:0]  mem_enc_dat,
   input  logic [ECC_AWID-1:0] mem_dec_addr,
   output logic                buf_req,
   input  logic                buf_gnt,
   output logic                buf_we,
   output logic [BUF_AWID-1:0] buf_addr,
   output logic [DAT_WID-1:0]  buf_wdat,
   input  logic [DAT_WID-1:0]  buf_rdat,
   output logic                wb_busy,
   output logic                wb_done,
   output logic                err_uncor,
   output logic [3:0]          cor_cnt
);

   localparam int IDX_W = $clog2(PAR_WORDS + 1);

   typedef enum logic [2:0] {
      IDLE, ENC_RD, ENC_WR, DEC_RD, DEC_BRD, DEC_BWR, DONE
   } state_t;

   state_t              state, state_nxt;
   logic [IDX_W-1:0]    idx;
   logic [3:0]          err_tgt;
   logic [ECC_AWID-1:0] addr_q;
   logic [DAT_WID-1:0]  wdat_q;
   logic                rd_d;
   logic                brd_d;
   logic                start;
   logic                fire;
   logic [BUF_AWID-1:0] enc_addr;
   logic [BUF_AWID-1:0] dec_addr;

   assign start    = nfc_ecc_opt && (ecc_enc_rdy || ecc_dec_rdy);
   assign fire     = buf_req && buf_gnt;
   assign enc_addr = par_base + BUF_AWID'(idx);
   assign dec_addr = sec_base + BUF_AWID'(addr_q[ECC_AWID-1:4]);
   assign wb_busy  = (state != IDLE);
   assign wb_done  = (state == DONE);

   // FIFO data and buffer read data land one cycle late, so the first cycle of
   // ENC_WR, DEC_BRD and DEC_BWR captures and keeps buf_req low.
   always_comb begin
      state_nxt = state;
      mem_if_rd = 1'b0;
      buf_req   = 1'b0;
      buf_we    = 1'b0;
      buf_addr  = '0;
      buf_wdat  = '0;
      case (state)
         IDLE: begin
            if (start) begin
               if (nfc_dat_dir)
                  state_nxt = ENC_RD;
               else if (err_cnt == 4'd0 || err_cnt > 4'(MAX_ERR))
                  state_nxt = DONE;
               else
                  state_nxt = DEC_RD;
            end
         end
         ENC_RD: begin
            mem_if_rd = 1'b1;
            state_nxt = ENC_WR;
         end
         ENC_WR: begin
            buf_req  = !rd_d;
            buf_we   = 1'b1;
            buf_addr = enc_addr;
            buf_wdat = wdat_q;
            if (!rd_d && buf_gnt)
               state_nxt = (idx + IDX_W'(1) < IDX_W'(PAR_WORDS)) ? ENC_RD : DONE;
         end
         DEC_RD: begin
            mem_if_rd = 1'b1;
            state_nxt = DEC_BRD;
         end
         DEC_BRD: begin
            buf_req  = !rd_d;
            buf_addr = dec_addr;
            if (!rd_d && buf_gnt)
               state_nxt = DEC_BWR;
         end
         DEC_BWR: begin
            buf_req  = !brd_d;
            buf_we   = 1'b1;
            buf_addr = dec_addr;
            buf_wdat = wdat_q;
            if (!brd_d && buf_gnt)
               state_nxt = (cor_cnt + 4'd1 == err_tgt) ? DONE : DEC_RD;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         err_tgt   <= '0;
         addr_q    <= '0;
         wdat_q    <= '0;
         rd_d      <= 1'b0;
         brd_d     <= 1'b0;
         err_uncor <= 1'b0;
         cor_cnt   <= '0;
      end else begin
         state <= state_nxt;
         rd_d  <= mem_if_rd;
         brd_d <= (state == DEC_BRD) && fire;
         if (state == IDLE && start) begin
            idx <= '0;
            if (!nfc_dat_dir) begin
               err_tgt   <= err_cnt;
               cor_cnt   <= '0;
               err_uncor <= (err_cnt > 4'(MAX_ERR));
            end
         end
         if (state == ENC_WR && rd_d)
            wdat_q <= mem_enc_dat;
         if (state == ENC_WR && fire)
            idx <= idx + IDX_W'(1);
         if (state == DEC_BRD && rd_d)
            addr_q <= mem_dec_addr;
         if (brd_d)
            wdat_q <= buf_rdat ^ (DAT_WID'(1) << addr_q[3:0]);
         if (state == DEC_BWR && fire)
            cor_cnt <= cor_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_nfc_ecc_wb.sv
// tb/tb_nfc_ecc_wb.sv - directed scoreboard bench for nfc_ecc_wb
module tb_nfc_ecc_wb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        nfc_dat_dir, nfc_ecc_opt, ecc_enc_rdy, ecc_dec_rdy;
   logic [3:0]  err_cnt;
   logic [11:0] sec_base, par_base;
   logic        mem_if_rd;
   logic [15:0] mem_enc_dat;
   logic [11:0] mem_dec_addr;
   logic        buf_req, buf_gnt, buf_we;
   logic [11:0] buf_addr;
   logic [15:0] buf_wdat, buf_rdat;
   logic        wb_busy, wb_done, err_uncor;
   logic [3:0]  cor_cnt;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

   logic [15:0] fifo_q[$];
   logic [27:0] exp_q[$];
   logic [15:0] bmem [0:4095];

   logic        p_rd = 1'b0, p_stall = 1'b0, p_we = 1'b0;
   logic [11:0] p_addr = '0;
   logic [15:0] p_wdat = '0;

   always #5 clk = ~clk;

   nfc_ecc_wb dut (
      .clk(clk), .rst_n(rst_n), .nfc_dat_dir(nfc_dat_dir), .nfc_ecc_opt(nfc_ecc_opt),
      .ecc_enc_rdy(ecc_enc_rdy), .ecc_dec_rdy(ecc_dec_rdy), .err_cnt(err_cnt),
      .sec_base(sec_base), .par_base(par_base), .mem_if_rd(mem_if_rd),
      .mem_enc_dat(mem_enc_dat), .mem_dec_addr(mem_dec_addr), .buf_req(buf_req),
      .buf_gnt(buf_gnt), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdat(buf_wdat),
      .buf_rdat(buf_rdat), .wb_busy(wb_busy), .wb_done(wb_done), .err_uncor(err_uncor),
      .cor_cnt(cor_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ECC FIFO and page buffer models: both answer the cycle after the request
   always @(posedge clk) begin
      logic [15:0] w;
      if (mem_if_rd && fifo_q.size() > 0) begin
         w = fifo_q.pop_front();
         mem_enc_dat  <= w;
         mem_dec_addr <= w[11:0];
      end
      if (buf_req && buf_gnt) begin
         if (buf_we) bmem[buf_addr] <= buf_wdat;
         else        buf_rdat <= bmem[buf_addr];
      end
   end

   always @(negedge clk) begin
      logic [27:0] e;
      if (rst_n) begin
         if (mem_if_rd) begin
            rd_cnt++;
            chk("rd_gap", {31'd0, p_rd}, 32'd0);
         end
         if (wb_done) done_cnt++;
         if (p_stall && buf_req) begin
            chk("stall_addr", {20'd0, buf_addr}, {20'd0, p_addr});
            chk("stall_wdat", {16'd0, buf_wdat}, {16'd0, p_wdat});
            chk("stall_we", {31'd0, buf_we}, {31'd0, p_we});
         end
         if (buf_req && buf_gnt && buf_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexpected_write", {20'd0, buf_addr}, 32'hFFFF_FFFF);
            else begin
               e = exp_q.pop_front();
               chk("wr_addr", {20'd0, buf_addr}, {20'd0, e[27:16]});
               chk("wr_data", {16'd0, buf_wdat}, {16'd0, e[15:0]});
            end
         end
      end
      p_rd    = mem_if_rd && rst_n;
      p_stall = buf_req && !buf_gnt && rst_n;
      p_addr  = buf_addr;
      p_wdat  = buf_wdat;
      p_we    = buf_we;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_enc();
      ecc_enc_rdy = 1'b1; tick(); ecc_enc_rdy = 1'b0;
   endtask

   task automatic pulse_dec();
      ecc_dec_rdy = 1'b1; tick(); ecc_dec_rdy = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin
         tick(); n++;
      end
      chk(tag, {31'd0, done_cnt > d0}, 32'd1);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, wb_busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, wb_done}, 32'd0);
      chk({tag, "_rd"}, {31'd0, mem_if_rd}, 32'd0);
      chk({tag, "_req"}, {31'd0, buf_req}, 32'd0);
      chk({tag, "_we"}, {31'd0, buf_we}, 32'd0);
      chk({tag, "_addr"}, {20'd0, buf_addr}, 32'd0);
      chk({tag, "_wdat"}, {16'd0, buf_wdat}, 32'd0);
      chk({tag, "_cor"}, {28'd0, cor_cnt}, 32'd0);
      chk({tag, "_uncor"}, {31'd0, err_uncor}, 32'd0);
   endtask

   initial begin
      int r0, w0, d0, n;
      for (int i = 0; i < 4096; i++) bmem[i] = '0;
      rst_n = 1'b0; nfc_dat_dir = 1'b1; nfc_ecc_opt = 1'b1;
      ecc_enc_rdy = 1'b0; ecc_dec_rdy = 1'b0; err_cnt = '0;
      sec_base = 12'h100; par_base = 12'h200; buf_gnt = 1'b1;
      mem_enc_dat = '0; mem_dec_addr = '0; buf_rdat = '0;
      tick(2);
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick();

      // encode: 7 parity words, a stray enc_rdy while busy must be dropped
      for (int i = 1; i <= 7; i++) begin
         fifo_q.push_back(16'(i * 16'h1111));
         exp_q.push_back({12'(12'h200 + i - 1), 16'(i * 16'h1111)});
      end
      r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
      pulse_enc();
      tick(3);
      pulse_enc();
      wait_done("enc_done", 200);
      tick(4);
      chk("enc_rd_cnt", rd_cnt - r0, 32'd7);
      chk("enc_wr_cnt", wr_cnt - w0, 32'd7);
      chk("enc_done_cnt", done_cnt - d0, 32'd1);
      chk("enc_idle", {31'd0, wb_busy}, 32'd0);
      chk("enc_buf_206", {16'd0, bmem[12'h206]}, 32'h7777);

      // decode with two correctable errors
      nfc_dat_dir = 1'b0; err_cnt = 4'd2;
      fifo_q.push_back(16'h0013); fifo_q.push_back(16'h00FF);
      exp_q.push_back({12'h101, 16'h0008}); exp_q.push_back({12'h10F, 16'h8000});
      r0 = rd_cnt;
      pulse_dec();
      wait_done("dec2_done", 200);
      chk("dec2_cor", {28'd0, cor_cnt}, 32'd2);
      chk("dec2_uncor", {31'd0, err_uncor}, 32'd0);
      chk("dec2_rd_cnt", rd_cnt - r0, 32'd2);
      chk("dec2_buf_10f", {16'd0, bmem[12'h10F]}, 32'h8000);

      // grant stall in DEC_BWR; dir/opt changes mid-operation are ignored
      err_cnt = 4'd1; buf_gnt = 1'b0;
      fifo_q.push_back(16'h0010);
      exp_q.push_back({12'h101, 16'h0009});
      w0 = wr_cnt;
      pulse_dec();
      n = 0;
      while (!buf_req && n < 20) begin tick(); n++; end
      chk("stall_rd_req", {31'd0, buf_req && !buf_we}, 32'd1);
      buf_gnt = 1'b1; tick(); buf_gnt = 1'b0;
      nfc_dat_dir = 1'b1; nfc_ecc_opt = 1'b0;
      n = 0;
      while (!(buf_req && buf_we) && n < 20) begin tick(); n++; end
      chk("stall_wr_req", {31'd0, buf_req && buf_we}, 32'd1);
      tick(5);
      chk("stall_no_write", wr_cnt - w0, 32'd0);
      buf_gnt = 1'b1;
      wait_done("stall_done", 50);
      chk("stall_one_write", wr_cnt - w0, 32'd1);
      chk("stall_cor", {28'd0, cor_cnt}, 32'd1);

      // uncorrectable, then err_cnt=0 clears the flag
      nfc_dat_dir = 1'b0; nfc_ecc_opt = 1'b1; err_cnt = 4'd9;
      r0 = rd_cnt; w0 = wr_cnt;
      pulse_dec();
      chk("unc_done_pulse", {31'd0, wb_done}, 32'd1);
      chk("unc_req", {31'd0, buf_req}, 32'd0);
      chk("unc_flag", {31'd0, err_uncor}, 32'd1);
      tick();
      chk("unc_done_one_cycle", {31'd0, wb_done}, 32'd0);
      chk("unc_no_rd", rd_cnt - r0, 32'd0);
      chk("unc_no_wr", wr_cnt - w0, 32'd0);
      err_cnt = 4'd0;
      pulse_dec();
      chk("zero_done_pulse", {31'd0, wb_done}, 32'd1);
      chk("zero_clears_uncor", {31'd0, err_uncor}, 32'd0);
      tick(2);

      // pulse with ECC disabled stays idle
      nfc_ecc_opt = 1'b0; nfc_dat_dir = 1'b1; d0 = done_cnt;
      pulse_enc();
      chk("opt0_busy", {31'd0, wb_busy}, 32'd0);
      tick(5);
      chk("opt0_no_done", done_cnt - d0, 32'd0);

      // reset in the middle of a stalled decode
      nfc_ecc_opt = 1'b1; nfc_dat_dir = 1'b0; err_cnt = 4'd1; buf_gnt = 1'b0;
      fifo_q.push_back(16'h0021);
      pulse_dec();
      tick(4);
      chk("mid_busy", {31'd0, wb_busy}, 32'd1);
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      check_idle_zero("mid_reset");
      tick(2);
      rst_n = 1'b1; buf_gnt = 1'b1;
      tick(10);
      chk("mid_no_done", done_cnt - d0, 32'd0);
      chk("exp_q_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nfc_ecc_wb.md
NFC_ECC_WB -- requirements
Module: nfc_ecc_wb

Interface
REQ-001 Parameter DAT_WID, 16: width of FIFO and page-buffer data words.
REQ-002 Parameter ECC_AWID, 12: width of decoder error bit address; [11:4] is the word index and [3:0] the bit index.
REQ-003 Parameter BUF_AWID, 12: page-buffer address width.
REQ-004 Parameter PAR_WORDS, 7: number of parity words per sector on encode.
REQ-005 Parameter MAX_ERR, 8: maximum correctable errors per sector.
REQ-006 Ports, in order:
- clk  in  1  system clock; the block uses one clock only.
- rst_n  in  1  reset, asynchronous, active-low.
- nfc_dat_dir  in  1  data direction: 1 = program (encode), 0 = read (decode).
- nfc_ecc_opt  in  1  ECC enable; 0 = all ready pulses are ignored.
- ecc_enc_rdy  in  1  one-cycle pulse: parity words are available in the ECC FIFO.
- ecc_dec_rdy  in  1  one-cycle pulse: error addresses are available in the ECC FIFO.
- err_cnt  in  4  number of error addresses; sampled at the accepted ready pulse.
- sec_base  in  BUF_AWID  page-buffer word address of sector word 0.
- par_base  in  BUF_AWID  page-buffer word address of parity word 0.
- mem_if_rd  out  1  ECC FIFO read strobe, one word per cycle asserted.
- mem_enc_dat  in  DAT_WID  FIFO parity word; valid the cycle after mem_if_rd.
- mem_dec_addr  in  ECC_AWID  FIFO error bit address; valid the cycle after mem_if_rd.
- buf_req  out  1  page-buffer access request.
- buf_gnt  in  1  grant; the access occurs in the cycle where buf_req and buf_gnt are both high.
- buf_we  out  1  1 = write, 0 = read.
- buf_addr  out  BUF_AWID  page-buffer word address.
- buf_wdat  out  DAT_WID  page-buffer write data.
- buf_rdat  in  DAT_WID  page-buffer read data; valid the cycle after a granted read.
- wb_busy  out  1  high whenever the state machine is not IDLE.
- wb_done  out  1  one-cycle completion pulse.
- err_uncor  out  1  sticky uncorrectable-sector flag.
- cor_cnt  out  4  number of bits corrected in the last sector.

Function
REQ-007 The FSM SHALL have the states IDLE, ENC_RD, ENC_WR, DEC_RD, DEC_BRD, DEC_BWR and DONE.
REQ-008 In IDLE, with nfc_ecc_opt=1, an ecc_enc_rdy or ecc_dec_rdy pulse SHALL be accepted as follows:
- nfc_dat_dir=1 → ENC_RD.
- nfc_dat_dir=0 → DEC_RD.
- Both pulses in the same cycle → one start only, with direction chosen by nfc_dat_dir.
REQ-009 Ready pulses arriving outside IDLE, or while nfc_ecc_opt=0, SHALL be dropped with no side effect.
REQ-010 ENC_RD SHALL assert mem_if_rd for exactly one cycle, then go to ENC_WR.
REQ-011 ENC_WR SHALL drive the following until granted:
- buf_req=1, buf_we=1.
- buf_addr = par_base + idx.
- buf_wdat = the captured mem_enc_dat.
REQ-012 On grant in ENC_WR, idx SHALL increment.
- If idx < PAR_WORDS, the FSM returns to ENC_RD.
- Otherwise it goes to DONE.
REQ-013 On decode start, the FSM SHALL latch err_cnt, clear cor_cnt, and then:
- err_cnt=0 → DONE directly, with no FIFO read.
- err_cnt > MAX_ERR → set err_uncor and go to DONE, with no FIFO read and no buffer write.
REQ-014 DEC_RD SHALL pulse mem_if_rd once, then capture mem_dec_addr the next cycle.
REQ-015 DEC_BRD SHALL hold the following until granted, then wait one cycle for buf_rdat:
- buf_req=1, buf_we=0.
- buf_addr = sec_base + addr[11:4].
REQ-016 DEC_BWR SHALL hold the following until granted:
- buf_req=1, buf_we=1, same buf_addr as the read.
- buf_wdat = buf_rdat with bit addr[3:0] inverted.
REQ-017 On grant in DEC_BWR, cor_cnt SHALL increment; the FSM then returns to DEC_RD until cor_cnt equals the latched count, and otherwise goes to DONE.
REQ-018 DONE SHALL pulse wb_done for one cycle and return to IDLE.
REQ-019 Address sums SHALL wrap modulo 2^BUF_AWID.
REQ-020 buf_req SHALL stay high, with stable address, data and we, until granted.
REQ-021 mem_if_rd SHALL never be high in two consecutive cycles.
REQ-022 The FSM SHALL issue exactly PAR_WORDS reads per encode and exactly err_cnt reads per correctable decode.
REQ-023 err_uncor SHALL clear only on reset or on the next accepted decode start with err_cnt ≤ MAX_ERR.
REQ-024 Changes to nfc_dat_dir or nfc_ecc_opt during an operation SHALL NOT affect it.

Reset
REQ-025 With rst_n low, the block SHALL asynchronously enter IDLE and clear the following to 0:
- mem_if_rd, buf_req, buf_we, buf_addr, buf_wdat.
- wb_busy, wb_done, err_uncor, cor_cnt.
- idx and the captured address and data registers.
REQ-026 Reset asserted mid-operation SHALL abort it with no wb_done; the FIFO read pointer is reset by its owner.

Verification
REQ-027 Encode: dir=1, opt=1, enc_rdy pulse, FIFO words 0x1111 through 0x7777, par_base=0x200, buf_gnt=1 → 7 writes to 0x200–0x206 with those values, 7 mem_if_rd pulses, then a wb_done pulse.
REQ-028 Decode with 2 errors: dir=0, err_cnt=2, addresses 0x013 and 0x0FF, sec_base=0x100, buffer all 0 → 0x101 written as 0x0008, 0x10F written as 0x8000, cor_cnt=2, wb_done.
REQ-029 Uncorrectable: err_cnt=9 → err_uncor=1, no mem_if_rd, no buf_req, wb_done one cycle after start; a following decode with err_cnt=0 → err_uncor=0.
REQ-030 Grant stall: buf_gnt held low for 5 cycles during DEC_BWR → buf_req, buf_addr and buf_wdat stable throughout; a single write occurs when granted.
REQ-031 Ignored pulses:
- An enc_rdy pulse while busy → no second operation starts.
- A pulse while opt=0 → remains in IDLE.
REQ-032 Reset: rst_n low in the middle of a decode → all outputs 0 immediately; no wb_done after release.
